// File: rtl/parity_stream.sv
// rtl/parity_stream.sv - streaming column-parity engine with per-frame result and beat count
module parity_stream #(
    parameter int DATA_WIDTH = 512,
    parameter int LANE_WIDTH = 64,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    input  logic                  mode_odd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANE_WIDTH-1:0] out_col,
    output logic                  out_bit,
    output logic [CNT_WIDTH-1:0]  out_beats
);
    localparam int NUM_LANES = DATA_WIDTH / LANE_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    generate
        if (DATA_WIDTH % LANE_WIDTH != 0) begin : g_width_check
            $error("DATA_WIDTH must be an integer multiple of LANE_WIDTH");
        end
    endgenerate

    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  s1_last;
    logic                  s1_first;
    logic                  s1_mode;
    logic                  armed;

    logic [LANE_WIDTH-1:0] acc;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  frame_mode;

    logic                  advance;
    logic                  accept;
    logic [LANE_WIDTH-1:0] fold;
    logic [LANE_WIDTH-1:0] acc_next;
    logic [CNT_WIDTH-1:0]  cnt_next;
    logic                  mode_next;

    // Only a last beat can be blocked, and only by an undrained result.
    assign advance  = s1_valid && (!s1_last || !out_valid || out_ready);
    assign in_ready = !s1_valid || advance;
    assign accept   = in_valid && in_ready;

    always_comb begin
        fold = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            fold = fold ^ s1_data[i*LANE_WIDTH +: LANE_WIDTH];
        end
    end

    assign acc_next  = (s1_first ? '0 : acc) ^ fold;
    assign cnt_next  = s1_first ? CNT_WIDTH'(1) : ((cnt == CNT_MAX) ? cnt : cnt + 1'b1);
    assign mode_next = s1_first ? s1_mode : frame_mode;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_last  <= 1'b0;
            s1_first <= 1'b0;
            s1_mode  <= 1'b0;
            armed    <= 1'b1;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_data  <= in_data;
            s1_last  <= in_last;
            s1_first <= armed;
            s1_mode  <= mode_odd;
            armed    <= in_last;
        end else if (advance) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc        <= '0;
            cnt        <= '0;
            frame_mode <= 1'b0;
            out_valid  <= 1'b0;
            out_col    <= '0;
            out_bit    <= 1'b0;
            out_beats  <= '0;
        end else begin
            if (advance) begin
                acc        <= acc_next;
                cnt        <= cnt_next;
                frame_mode <= mode_next;
            end
            // A fresh result overrides the clear from a same-cycle drain.
            if (advance && s1_last) begin
                out_valid <= 1'b1;
                out_col   <= acc_next;
                out_beats <= cnt_next;
                out_bit   <= (^acc_next) ^ mode_next;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_parity_stream.sv
// tb/tb_parity_stream.sv - directed-vector bench for parity_stream
module tb_parity_stream;
    localparam int DW = 512;
    localparam int LW = 64;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          mode_odd;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] out_col;
    logic          out_bit;
    logic [CW-1:0] out_beats;

    int n_vec = 0;
    int n_err = 0;

    parity_stream #(.DATA_WIDTH(DW), .LANE_WIDTH(LW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .mode_odd(mode_odd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_col(out_col), .out_bit(out_bit), .out_beats(out_beats)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] lane(input int idx, input logic [LW-1:0] v);
        logic [DW-1:0] d;
        d = '0;
        d[idx*LW +: LW] = v;
        return d;
    endfunction

    task automatic send_beat(input logic [DW-1:0] d, input logic last, input logic mode);
        int waited;
        waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        mode_odd = mode;
        while (!in_ready && waited < 100) begin
            step();
            waited++;
        end
        if (waited >= 100) check("send_timeout", 64'd0, 64'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_frame(input string tag, input logic [63:0] col, input logic b, input logic [CW-1:0] beats);
        int waited;
        waited = 0;
        out_ready = 1'b1;
        while (!out_valid && waited < 100) begin
            step();
            waited++;
        end
        if (waited >= 100) check({tag, "_timeout"}, 64'd0, 64'd1);
        check({tag, "_col"}, out_col, col);
        check({tag, "_bit"}, 64'(out_bit), 64'(b));
        check({tag, "_beats"}, 64'(out_beats), 64'(beats));
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        mode_odd = 1'b0; out_ready = 1'b0;
        step();
        step();
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_col", out_col, 64'd0);
        check("rst_out_bit", 64'(out_bit), 64'd0);
        check("rst_out_beats", 64'(out_beats), 64'd0);
        rst = 1'b0;

        // single beat, latency of two edges from presentation
        in_valid = 1'b1; in_data = lane(0, 64'hFF); in_last = 1'b1; mode_odd = 1'b0;
        step();
        in_valid = 1'b0; in_last = 1'b0;
        check("single_valid_edge1", 64'(out_valid), 64'd0);
        step();
        check("single_valid_edge2", 64'(out_valid), 64'd1);
        check("single_col", out_col, 64'hFF);
        check("single_bit", 64'(out_bit), 64'd0);
        check("single_beats", 64'(out_beats), 64'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("single_drained", 64'(out_valid), 64'd0);

        // three-beat odd frame
        send_beat({8{64'h1}}, 1'b0, 1'b1);
        send_beat(lane(3, 64'hA5), 1'b0, 1'b1);
        send_beat(lane(7, 64'h0F), 1'b1, 1'b1);
        expect_frame("three", 64'hAA, 1'b1, 4'd3);

        // back-to-back frames under backpressure
        send_beat(lane(0, 64'h11), 1'b1, 1'b0);
        send_beat(lane(0, 64'h07), 1'b1, 1'b0);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        step();
        step();
        check("bp_hold_valid", 64'(out_valid), 64'd1);
        check("bp_hold_col", out_col, 64'h11);
        check("bp_in_ready_still_low", 64'(in_ready), 64'd0);
        expect_frame("bp_first", 64'h11, 1'b0, 4'd1);
        expect_frame("bp_second", 64'h07, 1'b1, 4'd1);
        check("bp_empty", 64'(out_valid), 64'd0);

        // mode latched on first beat only
        send_beat(lane(0, 64'h1), 1'b0, 1'b1);
        send_beat(lane(2, 64'h0), 1'b1, 1'b0);
        expect_frame("mode", 64'h1, 1'b0, 4'd2);

        // reset mid-frame with a pending result
        send_beat(lane(0, 64'h9), 1'b1, 1'b0);
        send_beat(lane(0, 64'h5), 1'b0, 1'b0);
        send_beat(lane(1, 64'h6), 1'b0, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstmid_no_stale", 64'(out_valid), 64'd0);
        check("rstmid_in_ready", 64'(in_ready), 64'd1);
        send_beat(lane(0, 64'h3), 1'b1, 1'b0);
        expect_frame("rstmid", 64'h3, 1'b0, 4'd1);
        step();
        check("rstmid_empty", 64'(out_valid), 64'd0);

        // counter saturation at 4'hF
        for (int i = 0; i < 20; i++) begin
            send_beat(lane(0, 64'h1), (i == 19), 1'b0);
        end
        expect_frame("sat", 64'h0, 1'b0, 4'hF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/parity_stream.md
# parity_stream

Streaming, parametrised column-parity engine: it folds each DATA_WIDTH-bit input beat into LANE_WIDTH-bit column parity, accumulates the result across all beats of a frame, and emits one result per frame. It adds valid/ready handshaking with backpressure, frame delimiting, odd/even mode and a beat counter. It sits on the wide datapath wherever per-frame parity or check words are generated.

## Interface
- DATA_WIDTH, 512, input beat width; must be an integer multiple of LANE_WIDTH; elaboration error otherwise
- LANE_WIDTH, 64, column-parity width; NUM_LANES = DATA_WIDTH/LANE_WIDTH, derived
- CNT_WIDTH, 16, width of the per-frame beat counter
- clk  input  1  single clock; all logic on posedge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  beat offered
- in_ready  output  1  beat accepted when in_valid && in_ready
- in_data  input  DATA_WIDTH  beat payload; lane i = in_data[i*LANE_WIDTH +: LANE_WIDTH]
- in_last  input  1  beat is the final beat of its frame
- mode_odd  input  1  0 = even, 1 = odd; sampled with the first beat of each frame
- out_valid  output  1  frame result available
- out_ready  input  1  consumer takes result when out_valid && out_ready
- out_col  output  LANE_WIDTH  XOR of all lanes of all beats in the frame
- out_bit  output  1  (^out_col) ^ frame mode
- out_beats  output  CNT_WIDTH  number of beats in frame, saturating at all-ones

## Operation
- Stage 1 (input register): s1_valid, s1_data, s1_last, s1_first, s1_mode. Loaded on every accepted beat. s1_first is set on the first beat after reset or after a beat with in_last.
- Stage 2 (accumulator): fold = XOR of the NUM_LANES lanes of s1_data. When s1 advances: acc <= (s1_first ? 0 : acc) ^ fold. cnt <= s1_first ? 1 : sat(cnt+1). The mode register loads s1_mode when s1_first is set.
- Advance rule: s1 advances when s1_valid && (!s1_last || !out_valid || out_ready). Non-last beats never stall.
- When s1 advances with s1_last, the output register loads out_col = next acc, out_beats = next cnt, and out_bit = (^next acc) ^ frame mode. out_valid is set.
- A single-beat frame (first and last) yields out_col = fold and out_beats = 1.
- in_ready = !s1_valid || advance. Full throughput of one beat per cycle is sustained while the output register is drained each frame.
- out_valid clears on out_valid && out_ready, unless a new result loads in the same cycle. In that case the new result replaces the old and out_valid stays high.
- Output fields are held stable while out_valid && !out_ready.
- Beat counter saturates at 2^CNT_WIDTH-1. Parity accumulation continues correctly past saturation.
- in_data, in_last and mode_odd are ignored when in_valid is low. A mid-frame change of mode_odd has no effect on the current frame.

## Timing
- Reset values: in_ready=1, out_valid=0, out_col=0, out_bit=0, out_beats=0. Also s1_valid=0, acc=0, cnt=0, and s1_first state armed.
- Latency: the last beat is accepted at edge k. out_valid is high from edge k+1 (visible in the cycle after acceptance plus one register, i.e. 2 edges after being presented with ready high).
- Stall: the last beat is in s1 while out_valid && !out_ready. Then in_ready=0 the same cycle, and the beat waits in s1 until out_ready.
- Reset asserted mid-frame discards the partial frame and any pending result. The first beat after reset starts a new frame.
- The first beat of a frame may follow the previous last beat on the very next cycle. No idle cycle is required.

## Test plan
- Reset then single beat: DATA_WIDTH=512, lane0=64'hFF, other lanes 0, in_last=1, mode_odd=0. Required: out_col=64'hFF, out_bit=0, out_beats=1, out_valid 2 edges after presentation.
- Three-beat frame: all lanes=64'h1 in beat 1 (8 lanes cancel), beat 2 lane3=64'hA5, beat 3 lane7=64'h0F, mode_odd=1. Required: out_col=64'hAA, out_bit=1^0=1, out_beats=3.
- Backpressure: out_ready=0 while two back-to-back single-beat frames are sent. Required: first result held stable; in_ready drops while the second last beat sits in s1; on out_ready=1 the results arrive in order with no loss.
- Mode latch: mode_odd=1 on beat 1, 0 on beat 2 of a 2-beat frame whose XOR total is odd. Required: out_bit=0.
- Reset mid-frame: rst pulse after 2 of 4 beats, then a new 1-beat frame of 64'h3 in lane0. Required: out_col=64'h3, out_beats=1, no stale result.
- Saturation with CNT_WIDTH=4: a 20-beat frame of lane0=64'h1. Required: out_beats=4'hF, out_col=0.
